usb_tx_pkt_gen: RTL and testbench

// Next-generation transmit packet builder for token, SOF and handshake packets.

---
 rtl/usb_tx_pkt_gen.sv | 275 +++++++++++++++++++++++++++
 tb/tb_usb_tx_pkt_gen.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_pkt_gen.sv
// USB transmit packet builder for token, SOF and handshake packets.
// Commands are queued in a small FIFO. Each command is classified by its PID.
// The packet is sent as a byte stream: PID byte, then for tokens and SOF the
// 11-bit field and CRC5. The stream has sop/eop framing and valid/ready
// backpressure toward the serializer.
module usb_tx_pkt_gen #(
    parameter int FIFO_DEPTH = 4,
    parameter int IDLE_GAP   = 0,
    parameter int CNT_W      = 16,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_pid,
    input  logic [6:0]       cmd_addr,
    input  logic [3:0]       cmd_endp,
    input  logic [10:0]      cmd_frame,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sop,
    output logic             out_eop,
    output logic             busy,
    output logic             cmd_err,
    output logic [AW:0]      fifo_level,
    output logic [CNT_W-1:0] pkt_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_B1,
        ST_B2,
        ST_GAP
    } state_t;

    // FIFO entry layout: {pid, addr, endp, frame}
    localparam int EW = 26;
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [3:0]  GAP_LOAD   = 4'(IDLE_GAP);
    localparam bit          GAP_EN     = (IDLE_GAP > 0);

    // ---------------- command FIFO ----------------
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == FULL_LEVEL);
    assign empty = (level == '0);
    assign push  = cmd_valid & ~full;

    // Store accepted commands. The memory has no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {cmd_pid, cmd_addr, cmd_endp, cmd_frame};
        end
    end

    // Head of queue is read combinationally so IDLE can classify it and build the CRC at pop.
    logic [EW-1:0] head;
    logic [3:0]    head_pid;
    logic [6:0]    head_addr;
    logic [3:0]    head_endp;
    logic [10:0]   head_frame;
    logic [10:0]   head_field;

    assign head       = fifo_mem[rd_ptr_q[AW-1:0]];
    assign head_pid   = head[25:22];
    assign head_addr  = head[21:15];
    assign head_endp  = head[14:11];
    assign head_frame = head[10:0];

    // ---------------- PID classification ----------------
    logic head_is_tok;
    logic head_is_sof;
    logic head_is_hs;
    logic head_ok;

    // Sort the head PID into token / SOF / handshake. Anything else is unsupported.
    always_comb begin
        head_is_tok = 1'b0;
        head_is_sof = 1'b0;
        head_is_hs  = 1'b0;
        case (head_pid)
            4'b0001, 4'b1001, 4'b1101, 4'b0100: head_is_tok = 1'b1;
            4'b0101:                            head_is_sof = 1'b1;
            4'b0010, 4'b1010, 4'b1110, 4'b0110: head_is_hs  = 1'b1;
            default: ;
        endcase
    end

    assign head_ok    = head_is_tok | head_is_sof | head_is_hs;
    assign head_field = head_is_sof ? head_frame : {head_endp, head_addr};

    // ---------------- CRC5 over the 11-bit field ----------------
    logic [4:0] crc_c;
    logic [4:0] crc_tx;

    // Serial CRC5 (x^5+x^2+1, seed all ones), field bit 0 first, unrolled into one cycle.
    always_comb begin : crc_calc
        logic fb;
        fb    = 1'b0;
        crc_c = 5'b11111;
        for (int i = 0; i < 11; i++) begin
            fb    = head_field[i] ^ crc_c[4];
            crc_c = {crc_c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
    end

    // The transmitted CRC is the inverted register, MSB first on the wire.
    // Placing it bit-reversed in the LSB-first byte achieves that order.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_crc_tx
            assign crc_tx[gi] = ~crc_c[4-gi];
        end
    endgenerate

    // ---------------- packet FSM ----------------
    state_t           state_q, state_d;
    logic [10:0]      field_q, field_d;
    logic [4:0]       crc_q, crc_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_sop_q, out_sop_d;
    logic             out_eop_q, out_eop_d;
    logic             cmd_err_q, cmd_err_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic             xfer;
    logic             done;

    assign xfer = out_valid_q & out_ready;

    // Next-state and next-output logic. Each byte state advances only on an accepted transfer.
    always_comb begin
        state_d     = state_q;
        field_d     = field_q;
        crc_d       = crc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        cmd_err_d   = 1'b0;
        gap_cnt_d   = gap_cnt_q;
        pkt_cnt_d   = pkt_cnt_q;
        pop         = 1'b0;
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty && gap_cnt_q == 4'd0) begin
                    pop = 1'b1;
                    if (head_ok) begin
                        field_d     = head_field;
                        crc_d       = crc_tx;
                        out_data_d  = {~head_pid, head_pid};
                        out_valid_d = 1'b1;
                        out_sop_d   = 1'b1;
                        out_eop_d   = head_is_hs;
                        state_d     = ST_PID;
                    end else begin
                        // Unsupported PID: drop it, flag it, stay idle.
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ST_PID: begin
                if (xfer) begin
                    if (out_eop_q) begin
                        // A handshake packet is a single byte.
                        done = 1'b1;
                    end else begin
                        out_data_d = field_q[7:0];
                        out_sop_d  = 1'b0;
                        out_eop_d  = 1'b0;
                        state_d    = ST_B1;
                    end
                end
            end
            ST_B1: begin
                if (xfer) begin
                    out_data_d = {crc_q, field_q[10:8]};
                    out_eop_d  = 1'b1;
                    state_d    = ST_B2;
                end
            end
            ST_B2: begin
                if (xfer) begin
                    done = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q <= 4'd1) begin
                    gap_cnt_d = 4'd0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The last byte was accepted: close the packet, count it, and optionally hold off.
        if (done) begin
            out_valid_d = 1'b0;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;
            out_data_d  = 8'h00;
            pkt_cnt_d   = pkt_cnt_q + 1'b1;
            if (GAP_EN) begin
                gap_cnt_d = GAP_LOAD;
                state_d   = ST_GAP;
            end else begin
                state_d   = ST_IDLE;
            end
        end
    end

    // FIFO pointers advance independently, so a push and a pop in one cycle both take effect.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    // All state and registered outputs. Reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            field_q     <= '0;
            crc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            cmd_err_q   <= 1'b0;
            gap_cnt_q   <= '0;
            pkt_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            field_q     <= field_d;
            crc_q       <= crc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            cmd_err_q   <= cmd_err_d;
            gap_cnt_q   <= gap_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    assign cmd_ready  = ~full;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_sop    = out_sop_q;
    assign out_eop    = out_eop_q;
    assign cmd_err    = cmd_err_q;
    assign busy       = ~empty | (state_q != ST_IDLE);
    assign fifo_level = level;
    assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_usb_tx_pkt_gen.sv
// Testbench for usb_tx_pkt_gen: a table of known packets, hand-written
// corner-case sequences, and random traffic checked against a packet model.
module tb_usb_tx_pkt_gen;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_pid = '0;
    logic [6:0]  cmd_addr = '0;
    logic [3:0]  cmd_endp = '0;
    logic [10:0] cmd_frame = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sop;
    logic        out_eop;
    logic        busy;
    logic        cmd_err;
    logic [2:0]  fifo_level;
    logic [15:0] pkt_cnt;

    usb_tx_pkt_gen #(.FIFO_DEPTH(DEPTH), .IDLE_GAP(0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pid(cmd_pid),
        .cmd_addr(cmd_addr), .cmd_endp(cmd_endp), .cmd_frame(cmd_frame),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .busy(busy), .cmd_err(cmd_err),
        .fifo_level(fifo_level), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Transferred bytes and expected bytes, each packed as {eop, sop, data}.
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    int exp_pkts = 0;
    int exp_errs = 0;

    // Values sampled at the last falling edge.
    logic [7:0]  s_data;
    logic        s_valid, s_sop, s_eop, s_cmd_ready, s_busy, s_err;
    logic [2:0]  s_level;
    logic [15:0] s_pkt;

    int cyc = 0;
    int ready_mode = 0;   // 0: always ready, 1: never, 2: 1,0,0,1 pattern, 3: random
    int err_seen = 0;
    int valid_seen = 0;
    int last_eop_cyc = -1;
    int last_gap = -1;
    bit stall_prev = 1'b0;
    logic [9:0] prev_byte = '0;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample at the falling edge, then drive out_ready just after the rising edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        s_data = out_data; s_valid = out_valid; s_sop = out_sop; s_eop = out_eop;
        s_cmd_ready = cmd_ready; s_busy = busy; s_err = cmd_err;
        s_level = fifo_level; s_pkt = pkt_cnt;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk_eq("hold_stable", {s_valid, s_eop, s_sop, s_data}, {1'b1, prev_byte});
            if (s_valid && out_ready) begin
                got_q.push_back({s_eop, s_sop, s_data});
                if (s_sop && last_eop_cyc >= 0) last_gap = cyc - last_eop_cyc;
                if (s_eop) last_eop_cyc = cyc;
            end
            if (s_err) err_seen++;
            if (s_valid) valid_seen++;
            stall_prev = s_valid && !out_ready;
            prev_byte = {s_eop, s_sop, s_data};
        end
        @(posedge clk);
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            2: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic set_ready_mode(input int m);
        ready_mode = m;
        if (m == 0) out_ready = 1'b1;
        if (m == 1) out_ready = 1'b0;
    endtask

    // Reference CRC5: shift the field in LSB first, then send the complement MSB first.
    function automatic logic [4:0] crc_ref(input logic [10:0] field);
        int c = 31;
        int tx = 0;
        for (int i = 0; i < 11; i++) begin
            if ((((c >> 4) & 1) ^ int'(field[i])) != 0) c = ((c << 1) & 31) ^ 5;
            else c = (c << 1) & 31;
        end
        for (int i = 0; i < 5; i++)
            if (((c >> (4 - i)) & 1) == 0) tx = tx | (1 << i);
        return 5'(tx);
    endfunction

    // Packet model: what each command should turn into on the byte stream.
    task automatic model_push(input logic [3:0] pid, input logic [6:0] addr,
                              input logic [3:0] endp, input logic [10:0] frame);
        logic [10:0] field;
        logic [7:0]  pb;
        bit tok, sof, hs;
        tok = (pid == 4'h1) || (pid == 4'h9) || (pid == 4'hD) || (pid == 4'h4);
        sof = (pid == 4'h5);
        hs  = (pid == 4'h2) || (pid == 4'hA) || (pid == 4'hE) || (pid == 4'h6);
        pb  = {~pid, pid};
        field = sof ? frame : {endp, addr};
        if (hs) begin
            exp_q.push_back({2'b11, pb});
            exp_pkts++;
        end else if (tok || sof) begin
            exp_q.push_back({2'b01, pb});
            exp_q.push_back({2'b00, field[7:0]});
            exp_q.push_back({2'b10, crc_ref(field), field[10:8]});
            exp_pkts++;
        end else begin
            exp_errs++;
        end
    endtask

    // Offer one command and wait (bounded) until it is accepted.
    task automatic push_cmd(input logic [3:0] pid, input logic [6:0] addr,
                            input logic [3:0] endp, input logic [10:0] frame);
        bit accepted = 1'b0;
        cmd_pid = pid; cmd_addr = addr; cmd_endp = endp; cmd_frame = frame;
        cmd_valid = 1'b1;
        for (int n = 0; n < 300 && !accepted; n++) begin
            step();
            if (s_cmd_ready) accepted = 1'b1;
        end
        cmd_valid = 1'b0;
        if (!accepted) chk_eq("push_timeout", 32'(accepted), 32'd1);
    endtask

    // Run until the block is idle with nothing on the output (bounded).
    task automatic drain();
        bit idle = 1'b0;
        for (int n = 0; n < 3000 && !idle; n++) begin
            step();
            if (!s_busy && !s_valid) idle = 1'b1;
        end
        chk_eq("drain_done", 32'(idle), 32'd1);
    endtask

    // Compare everything transferred so far with the model, then clear both queues.
    task automatic compare_all(input string tag);
        chk_eq({tag, "_byte_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk_eq({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
        chk_eq({tag, "_pkt_cnt"}, 32'(s_pkt), 32'(exp_pkts[15:0]));
        chk_eq({tag, "_err_cnt"}, err_seen, exp_errs);
    endtask

    typedef struct {
        logic [3:0]  pid;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [10:0] frame;
        int          nb;
        logic [7:0]  b0, b1, b2;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{4'b0001, 7'd0, 4'd0, 11'd0, 3, 8'hE1, 8'h00, 8'h10}; // OUT
        tbl[1] = '{4'b1001, 7'd0, 4'd0, 11'd0, 3, 8'h69, 8'h00, 8'h10}; // IN
        tbl[2] = '{4'b1101, 7'd0, 4'd0, 11'd0, 3, 8'h2D, 8'h00, 8'h10}; // SETUP
        tbl[3] = '{4'b0100, 7'd0, 4'd0, 11'd0, 3, 8'hB4, 8'h00, 8'h10}; // PING
        tbl[4] = '{4'b0101, 7'd0, 4'd0, 11'd0, 3, 8'hA5, 8'h00, 8'h10}; // SOF
        tbl[5] = '{4'b0010, 7'd9, 4'd3, 11'd7, 1, 8'hD2, 8'h00, 8'h00}; // ACK
        tbl[6] = '{4'b1010, 7'd0, 4'd0, 11'd0, 1, 8'h5A, 8'h00, 8'h00}; // NAK
        tbl[7] = '{4'b1110, 7'd0, 4'd0, 11'd0, 1, 8'h1E, 8'h00, 8'h00}; // STALL
        tbl[8] = '{4'b0110, 7'd0, 4'd0, 11'd0, 1, 8'h96, 8'h00, 8'h00}; // NYET

        // ---- reset state ----
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        chk_eq("rst_out_valid", 32'(s_valid), 32'd0);
        chk_eq("rst_cmd_ready", 32'(s_cmd_ready), 32'd1);
        chk_eq("rst_busy", 32'(s_busy), 32'd0);
        chk_eq("rst_level", 32'(s_level), 32'd0);
        chk_eq("rst_pkt_cnt", 32'(s_pkt), 32'd0);
        chk_eq("rst_outs", {s_data, s_sop, s_eop, s_err}, 32'd0);

        // ---- latency: SETUP pushed at edge T is visible in cycle T+2 ----
        cmd_pid = 4'b1101; cmd_addr = '0; cmd_endp = '0; cmd_frame = '0;
        cmd_valid = 1'b1;
        step();                              // push happens at this edge (T)
        cmd_valid = 1'b0;
        step();                              // sample cycle T+1
        chk_eq("lat_t1_valid", 32'(s_valid), 32'd0);
        chk_eq("lat_t1_level", 32'(s_level), 32'd1);
        chk_eq("lat_t1_busy", 32'(s_busy), 32'd1);
        step();                              // sample cycle T+2
        chk_eq("lat_t2_byte", {s_valid, s_sop, s_eop, s_data}, {3'b110, 8'h2D});
        exp_pkts++;
        drain();
        chk_eq("lat_nbytes", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk_eq("lat_b0", 32'(got_q[0]), {22'd0, 2'b01, 8'h2D});
            chk_eq("lat_b1", 32'(got_q[1]), {22'd0, 2'b00, 8'h00});
            chk_eq("lat_b2", 32'(got_q[2]), {22'd0, 2'b10, 8'h10});
        end
        got_q.delete();

        // ---- table of known packets ----
        for (int v = 0; v < 9; v++) begin
            push_cmd(tbl[v].pid, tbl[v].addr, tbl[v].endp, tbl[v].frame);
            exp_pkts++;
            drain();
            chk_eq($sformatf("tbl%0d_nbytes", v), got_q.size(), tbl[v].nb);
            if (got_q.size() == tbl[v].nb) begin
                if (tbl[v].nb == 1) begin
                    chk_eq($sformatf("tbl%0d_b0", v), 32'(got_q[0]), {22'd0, 2'b11, tbl[v].b0});
                end else begin
                    chk_eq($sformatf("tbl%0d_b0", v), 32'(got_q[0]), {22'd0, 2'b01, tbl[v].b0});
                    chk_eq($sformatf("tbl%0d_b1", v), 32'(got_q[1]), {22'd0, 2'b00, tbl[v].b1});
                    chk_eq($sformatf("tbl%0d_b2", v), 32'(got_q[2]), {22'd0, 2'b10, tbl[v].b2});
                end
            end
            got_q.delete();
            chk_eq($sformatf("tbl%0d_pkt_cnt", v), 32'(s_pkt), 32'(exp_pkts));
        end

        // ---- ACK then NAK back-to-back: one idle cycle between them ----
        push_cmd(4'b0010, '0, '0, '0);
        push_cmd(4'b1010, '0, '0, '0);
        exp_pkts += 2;
        drain();
        chk_eq("b2b_nbytes", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk_eq("b2b_ack", 32'(got_q[0]), {22'd0, 2'b11, 8'hD2});
            chk_eq("b2b_nak", 32'(got_q[1]), {22'd0, 2'b11, 8'h5A});
        end
        chk_eq("b2b_gap", last_gap, 2);
        chk_eq("b2b_pkt_cnt", 32'(s_pkt), 32'(exp_pkts));
        got_q.delete();

        // ---- SOF frame 0 with out_ready toggling ----
        set_ready_mode(2);
        push_cmd(4'b0101, '0, '0, 11'd0);
        exp_pkts++;
        drain();
        chk_eq("sof_nbytes", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk_eq("sof_b0", 32'(got_q[0]), {22'd0, 2'b01, 8'hA5});
            chk_eq("sof_b1", 32'(got_q[1]), {22'd0, 2'b00, 8'h00});
            chk_eq("sof_b2", 32'(got_q[2]), {22'd0, 2'b10, 8'h10});
        end
        got_q.delete();

        // ---- full FIFO: six IN tokens with the output stalled ----
        set_ready_mode(1);
        err_seen = 0; exp_errs = 0;
        for (int k = 0; k < 5; k++) begin
            logic [6:0] a = 7'($urandom_range(0, 127));
            logic [3:0] e = 4'($urandom_range(0, 15));
            push_cmd(4'b1001, a, e, '0);
            model_push(4'b1001, a, e, '0);
        end
        cmd_pid = 4'b1001; cmd_addr = 7'h55; cmd_endp = 4'hA; cmd_frame = '0;
        cmd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_eq("full_cmd_ready", 32'(s_cmd_ready), 32'd0);
            chk_eq("full_level", 32'(s_level), 32'(DEPTH));
        end
        set_ready_mode(0);
        begin
            bit acc = 1'b0;
            for (int n = 0; n < 300 && !acc; n++) begin
                step();
                if (s_cmd_ready) acc = 1'b1;
            end
            chk_eq("full_sixth_accepted", 32'(acc), 32'd1);
        end
        cmd_valid = 1'b0;
        model_push(4'b1001, 7'h55, 4'hA, '0);
        drain();
        compare_all("full");

        // ---- unsupported PID (DATA0) then ACK ----
        err_seen = 0; valid_seen = 0; exp_errs = 0;
        push_cmd(4'b0011, 7'd1, 4'd1, 11'd1);
        model_push(4'b0011, 7'd1, 4'd1, 11'd1);
        for (int k = 0; k < 5; k++) step();
        chk_eq("data0_err_pulses", err_seen, 1);
        chk_eq("data0_no_valid", valid_seen, 0);
        chk_eq("data0_idle", 32'(s_busy), 32'd0);
        push_cmd(4'b0010, '0, '0, '0);
        model_push(4'b0010, '0, '0, '0);
        drain();
        chk_eq("data0_ack_nbytes", got_q.size(), 1);
        if (got_q.size() == 1) chk_eq("data0_ack", 32'(got_q[0]), {22'd0, 2'b11, 8'hD2});
        compare_all("data0");

        // ---- random traffic against the packet model ----
        err_seen = 0; exp_errs = 0;
        set_ready_mode(3);
        for (int k = 0; k < 40; k++) begin
            logic [3:0]  p = 4'($urandom_range(0, 15));
            logic [6:0]  a = 7'($urandom_range(0, 127));
            logic [3:0]  e = 4'($urandom_range(0, 15));
            logic [10:0] f = 11'($urandom_range(0, 2047));
            int idle = $urandom_range(0, 3);
            push_cmd(p, a, e, f);
            model_push(p, a, e, f);
            for (int j = 0; j < idle; j++) step();
        end
        drain();
        compare_all("rand");

        // ---- reset while the second byte of a token is pending ----
        set_ready_mode(1);
        push_cmd(4'b1101, 7'd5, 4'd3, '0);
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                step();
                if (s_valid) seen = 1'b1;
            end
            chk_eq("rstmid_pid_seen", 32'(seen), 32'd1);
        end
        set_ready_mode(0);
        step();                              // PID byte transferred
        set_ready_mode(1);
        step();
        chk_eq("rstmid_b1_pending", {s_valid, s_sop, s_eop, s_data}, {3'b100, 8'h85});
        rst = 1'b1;
        step();
        rst = 1'b0;
        got_q.delete(); exp_q.delete(); exp_pkts = 0; err_seen = 0; exp_errs = 0;
        last_eop_cyc = -1;
        step();
        chk_eq("rstmid_valid", 32'(s_valid), 32'd0);
        chk_eq("rstmid_level", 32'(s_level), 32'd0);
        chk_eq("rstmid_pkt_cnt", 32'(s_pkt), 32'd0);
        chk_eq("rstmid_cmd_ready", 32'(s_cmd_ready), 32'd1);
        chk_eq("rstmid_busy", 32'(s_busy), 32'd0);

        // Recovery after reset: a fresh ACK goes out and is counted from zero.
        set_ready_mode(0);
        push_cmd(4'b0010, '0, '0, '0);
        model_push(4'b0010, '0, '0, '0);
        drain();
        compare_all("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
